spi_mem_bridge: RTL and testbench

- Downstream of the RISC-V core's data/instruction memory port; replaces the on-die memory array with an external SPI SRAM/PSRAM attached to the uio pins.
- Accepts one core load/store at a time and serializes it as a standard SPI RAM transaction (READ 0x03 / WRITE 0x02, 24-bit address, data bytes).
- Returns load data sign/zero-extended per funct3 and pulses memory_response on completion.

---
 rtl/spi_mem_pkg.sv | 58 +++++
 rtl/spi_shifter.sv | 94 +++++++++
 rtl/spi_mem_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_mem_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_mem_pkg
// Description : Shared definitions for the SPI memory bridge. Holds the SPI
//               RAM opcodes, the RISC-V funct3 load/store size codes, the
//               bridge FSM state type, and helpers for the transfer length
//               and load-result extension.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package spi_mem_pkg;

  localparam logic [7:0] SPI_READ  = 8'h03;
  localparam logic [7:0] SPI_WRITE = 8'h02;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Bytes moved in the data phase; the unused size code 11 moves a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Sign/zero extension of the little-endian assembled load word.
  function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                              input logic [31:0] raw);
    logic [31:0] res;
    case (f3)
      F3_B:    res = {{24{raw[7]}}, raw[7:0]};
      F3_H:    res = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   res = {24'h000000, raw[7:0]};
      F3_HU:   res = {16'h0000, raw[15:0]};
      F3_W:    res = raw;
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_shifter
// Description : Mode-0 SPI byte engine. Generates SCLK (half period CLK_DIV
//               clk cycles) and shifts one byte out on MOSI MSB first while
//               shifting one byte in from MISO. A load on the cycle that
//               o_byte_done is high chains the next byte with no idle clock.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_load          - start a byte (priority over running byte)
//               i_byte_in       - byte to transmit
//               i_miso          - serial input, sampled as SCLK rises
//               o_sclk, o_mosi  - registered SPI outputs
//               o_byte_out      - last received byte
//               o_byte_done     - high on the edge that ends the 8th bit
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_byte_in,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic [7:0] o_byte_out,
  output logic       o_byte_done
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             r_active;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [6:0]       r_tx;     // bits still to send after the one on MOSI
  logic [7:0]       r_rx;
  logic             r_sclk;
  logic             r_mosi;
  logic             w_half_end;

  assign w_half_end  = r_active && (r_div == DIV_LAST);
  assign o_byte_done = w_half_end && r_sclk && (r_bit == 3'd7);
  assign o_byte_out  = r_rx;
  assign o_sclk      = r_sclk;
  assign o_mosi      = r_mosi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bit    <= 3'd0;
      r_tx     <= 7'd0;
      r_rx     <= 8'd0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
    end else if (i_load) begin
      // First bit goes out immediately so it is stable a full half period
      // before the first rising edge.
      r_active <= 1'b1;
      r_div    <= '0;
      r_bit    <= 3'd0;
      r_tx     <= i_byte_in[6:0];
      r_sclk   <= 1'b0;
      r_mosi   <= i_byte_in[7];
    end else if (r_active) begin
      if (w_half_end) begin
        r_div <= '0;
        if (!r_sclk) begin
          // Capture MISO as SCLK rises; the slave has held it since the
          // previous falling edge.
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[6:0], i_miso};
        end else begin
          r_sclk <= 1'b0;
          if (r_bit == 3'd7) begin
            r_active <= 1'b0;
            r_mosi   <= 1'b0;
          end else begin
            r_bit  <= r_bit + 3'd1;
            r_mosi <= r_tx[6];
            r_tx   <= {r_tx[5:0], 1'b0};
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_mem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_mem_bridge
// Description : Core load/store port to external SPI SRAM/PSRAM. Each access
//               becomes one READ(0x03)/WRITE(0x02) transaction: opcode,
//               ADDR_BITS address MSB first, then 1/2/4 data bytes starting
//               at the addressed byte (little-endian). Loads are extended
//               per funct3 and every completion pulses memory_response.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               memory_read/memory_write   - request levels (write wins)
//               option                     - funct3 size code
//               address, write_data        - access address / store data
//               read_data                  - extended load result (held)
//               memory_response            - one-cycle completion pulse
//               busy                       - transaction in progress
//               spi_sclk/cs_n/mosi/miso    - SPI mode-0 bus
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int CLK_DIV   = 1,
  parameter int ADDR_BITS = 24,   // multiple of 8, at most 32
  parameter int CS_HIGH   = 2     // at least 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  option,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memory_response,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int ADDR_BYTES = ADDR_BITS / 8;
  localparam int GAP_W      = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;

  state_t                r_state;
  logic                  r_is_write;
  logic [2:0]            r_opt;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rbuf;
  logic [2:0]            r_idx;     // byte index within ADDR or DATA phase
  logic [GAP_W-1:0]      r_gap;
  logic                  r_cs_n;
  logic                  r_busy;
  logic                  r_resp;
  logic [31:0]           r_read_data;

  logic                  w_req;
  logic                  w_load;
  logic [7:0]            w_load_byte;
  logic                  w_byte_done;
  logic [7:0]            w_rx_byte;
  logic [2:0]            w_nbytes;
  logic [2:0]            w_next_idx;
  logic                  w_last_addr;
  logic                  w_last_data;
  logic [2:0]            w_addr_k;
  logic [2:0]            w_addr_rem;
  logic [ADDR_BITS-1:0]  w_addr_shifted;
  logic [1:0]            w_data_k;
  logic [7:0]            w_data_byte;
  logic [31:0]           w_word;

  // Core address bits above ADDR_BITS never reach the bus.
  if (ADDR_BITS < 32) begin : g_unused_addr
    logic w_unused_addr;
    assign w_unused_addr = ^address[31:ADDR_BITS];
  end

  assign w_req       = memory_read | memory_write;
  assign w_nbytes    = byte_count(r_opt[1:0]);
  assign w_next_idx  = r_idx + 3'd1;
  assign w_last_addr = (r_idx == 3'(ADDR_BYTES - 1));
  assign w_last_data = (w_next_idx == w_nbytes);

  // Next address byte to send, counted from the MSB end.
  assign w_addr_k       = (r_state == ST_CMD) ? 3'd0 : w_next_idx;
  assign w_addr_rem     = 3'(ADDR_BYTES - 1) - w_addr_k;
  assign w_addr_shifted = r_addr >> {w_addr_rem, 3'b000};

  // Next data byte to send; reads clock out zeros during the data phase.
  assign w_data_k    = (r_state == ST_ADDR) ? 2'd0 : w_next_idx[1:0];
  assign w_data_byte = r_is_write ? r_wdata[{w_data_k, 3'b000} +: 8] : 8'h00;

  // Received word including the byte that completes on this edge.
  always_comb begin
    w_word = r_rbuf;
    w_word[{r_idx[1:0], 3'b000} +: 8] = w_rx_byte;
  end

  // Byte feed to the shifter; loading on the done edge keeps SCLK gapless.
  always_comb begin
    w_load      = 1'b0;
    w_load_byte = 8'h00;
    case (r_state)
      ST_IDLE: if (w_req) begin
        w_load      = 1'b1;
        w_load_byte = memory_write ? SPI_WRITE : SPI_READ;
      end
      ST_CMD: if (w_byte_done) begin
        w_load      = 1'b1;
        w_load_byte = w_addr_shifted[7:0];
      end
      ST_ADDR: if (w_byte_done) begin
        w_load      = 1'b1;
        w_load_byte = w_last_addr ? w_data_byte : w_addr_shifted[7:0];
      end
      ST_DATA: if (w_byte_done && !w_last_data) begin
        w_load      = 1'b1;
        w_load_byte = w_data_byte;
      end
      default: ;
    endcase
  end

  spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_byte_in   (w_load_byte),
    .i_miso      (spi_miso),
    .o_sclk      (spi_sclk),
    .o_mosi      (spi_mosi),
    .o_byte_out  (w_rx_byte),
    .o_byte_done (w_byte_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_opt       <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_rbuf      <= 32'd0;
      r_idx       <= 3'd0;
      r_gap       <= '0;
      r_cs_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_resp      <= 1'b0;
      r_read_data <= 32'd0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_is_write <= memory_write;
            r_opt      <= option;
            r_addr     <= address[ADDR_BITS-1:0];
            r_wdata    <= write_data;
            r_busy     <= 1'b1;
            r_cs_n     <= 1'b0;
            r_idx      <= 3'd0;
            r_state    <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (w_byte_done) begin
            r_idx   <= 3'd0;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_byte_done) begin
            if (w_last_addr) begin
              r_idx   <= 3'd0;
              r_state <= ST_DATA;
            end else begin
              r_idx <= w_next_idx;
            end
          end
        end
        ST_DATA: begin
          if (w_byte_done) begin
            r_rbuf <= w_word;
            if (w_last_data) begin
              r_cs_n  <= 1'b1;
              r_resp  <= 1'b1;
              r_gap   <= '0;
              r_state <= ST_GAP;
              if (!r_is_write) begin
                r_read_data <= extend_load(r_opt, w_word);
              end
            end else begin
              r_idx <= w_next_idx;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_W'(CS_HIGH - 1)) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign read_data       = r_read_data;
  assign memory_response = r_resp;
  assign busy            = r_busy;
  assign spi_cs_n        = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_mem_bridge
// Description : Directed bench for spi_mem_bridge. Two instances (CLK_DIV=1
//               and CLK_DIV=3) share one behavioural SPI SRAM selected by
//               'sel'. Expected load results are queued when a request is
//               driven and popped on memory_response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        rd1, wr1, rd3, wr3;
  logic [2:0]  opt1, opt3;
  logic [31:0] addr1, wd1, addr3, wd3;
  logic [31:0] rdata1, rdata3;
  logic        resp1, busy1, sclk1, cs1, mosi1;
  logic        resp3, busy3, sclk3, cs3, mosi3;
  logic        miso;

  spi_mem_bridge #(.CLK_DIV(1), .ADDR_BITS(24), .CS_HIGH(2)) dut (
    .clk(clk), .rst_n(rst_n), .memory_read(rd1), .memory_write(wr1),
    .option(opt1), .address(addr1), .write_data(wd1), .read_data(rdata1),
    .memory_response(resp1), .busy(busy1), .spi_sclk(sclk1),
    .spi_cs_n(cs1), .spi_mosi(mosi1), .spi_miso(miso));

  spi_mem_bridge #(.CLK_DIV(3), .ADDR_BITS(24), .CS_HIGH(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .memory_read(rd3), .memory_write(wr3),
    .option(opt3), .address(addr3), .write_data(wd3), .read_data(rdata3),
    .memory_response(resp3), .busy(busy3), .spi_sclk(sclk3),
    .spi_cs_n(cs3), .spi_mosi(mosi3), .spi_miso(miso));

  // Bus selection towards the shared SPI RAM model.
  logic        sel = 1'b0;
  logic        sclk_m, cs_m, mosi_m, resp_m, busy_m;
  logic [31:0] rdata_m;
  assign sclk_m  = sel ? sclk3  : sclk1;
  assign cs_m    = sel ? cs3    : cs1;
  assign mosi_m  = sel ? mosi3  : mosi1;
  assign resp_m  = sel ? resp3  : resp1;
  assign busy_m  = sel ? busy3  : busy1;
  assign rdata_m = sel ? rdata3 : rdata1;

  // ---------------- SPI SRAM model (mode 0) ----------------
  logic [7:0]  mem [0:1023];
  logic [7:0]  cap_q [$];
  int          m_bits = 0;
  logic [7:0]  m_sh   = 8'h00;
  logic [7:0]  m_cmd  = 8'h00;
  logic [23:0] m_addr = 24'h0;
  int          m_widx;
  int          m_ridx;

  always @(posedge sclk_m or posedge cs_m) begin
    if (cs_m) begin
      m_bits = 0;
    end else begin
      m_sh   = {m_sh[6:0], mosi_m};
      m_bits = m_bits + 1;
      if (m_bits % 8 == 0) begin
        cap_q.push_back(m_sh);
        if (m_bits == 8) m_cmd = m_sh;
        else if (m_bits <= 32) m_addr = {m_addr[15:0], m_sh};
        else if (m_cmd == 8'h02) begin
          m_widx = (int'(m_addr) + (m_bits - 40) / 8) & 1023;
          mem[m_widx] = m_sh;
        end
      end
    end
  end

  always @(negedge sclk_m) begin
    if (!cs_m && m_cmd == 8'h03 && m_bits >= 32) begin
      m_ridx = (int'(m_addr) + (m_bits - 32) / 8) & 1023;
      miso = mem[m_ridx][7 - (m_bits % 8)];
    end
  end

  // ---------------- checking ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_q [$];
  logic [31:0] last_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic s, input logic rd, input logic wr,
                           input logic [2:0] opt, input logic [31:0] a,
                           input logic [31:0] wd);
    if (s) begin rd3 = rd; wr3 = wr; opt3 = opt; addr3 = a; wd3 = wd; end
    else   begin rd1 = rd; wr1 = wr; opt1 = opt; addr1 = a; wd1 = wd; end
  endtask

  // One complete access with bounded wait; checks data, framing and MOSI.
  task automatic access(input logic s, input logic rd, input logic wr,
                        input logic [2:0] opt, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input string tag);
    int n, div, cs_cnt, hi_cnt, rsp_cnt;
    logic done;
    logic [31:0] e, got_exp;
    logic [7:0] exp_b [$];
    n   = (opt[1:0] == 2'b00) ? 1 : (opt[1:0] == 2'b01) ? 2 : 4;
    div = s ? 3 : 1;
    e   = wr ? last_rd[s] : exp_rd;
    last_rd[s] = e;
    exp_b = {};
    exp_b.push_back(wr ? 8'h02 : 8'h03);
    exp_b.push_back(a[23:16]);
    exp_b.push_back(a[15:8]);
    exp_b.push_back(a[7:0]);
    if (wr) for (int k = 0; k < n; k++) exp_b.push_back(wd[8*k +: 8]);
    sb_q.push_back(e);
    cap_q = {};
    sel   = s;
    @(negedge clk);
    drive_req(s, rd, wr, opt, a, wd);
    @(posedge clk);
    #1 drive_req(s, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    cs_cnt = 0; hi_cnt = 0; rsp_cnt = 0; done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (!cs_m) cs_cnt++;
      if (sclk_m) hi_cnt++;
      if (resp_m) begin
        rsp_cnt++;
        got_exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        chk({tag, " read_data@resp"}, rdata_m, got_exp);
      end
      if (rsp_cnt > 0 && !busy_m) done = 1'b1;
    end
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " resp_pulses"}, 32'(rsp_cnt), 32'd1);
    chk({tag, " cs_low_cycles"}, 32'(cs_cnt), 32'(2 * div * (32 + 8 * n)));
    chk({tag, " sclk_high_cycles"}, 32'(hi_cnt), 32'(div * (32 + 8 * n)));
    chk({tag, " mosi_byte_count"}, 32'(cap_q.size()), 32'(4 + n));
    for (int i = 0; i < exp_b.size() && i < cap_q.size(); i++)
      chk($sformatf("%s mosi_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp_b[i]));
    chk({tag, " read_data_hold"}, rdata_m, e);
  endtask

  initial begin
    int gap, cnt;
    logic seen;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[1] = 8'h34; mem[2] = 8'h92; mem[3] = 8'h80;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    miso = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst cs_n", 32'(cs1), 32'd1);
    chk("rst sclk", 32'(sclk1), 32'd0);
    chk("rst mosi", 32'(mosi1), 32'd0);
    chk("rst busy", 32'(busy1), 32'd0);
    chk("rst resp", 32'(resp1), 32'd0);
    chk("rst read_data", rdata1, 32'd0);

    access(1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'd0, "SW");
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'h1234_5678, "LW");
    access(1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_0003, 32'd0, 32'hFFFF_FF80, "LB");
    access(1'b0, 1'b1, 1'b0, 3'b100, 32'h0000_0003, 32'd0, 32'h0000_0080, "LBU");
    access(1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0001, 32'd0, 32'hFFFF_9234, "LH");
    access(1'b0, 1'b1, 1'b0, 3'b101, 32'h0000_0001, 32'd0, 32'h0000_9234, "LHU");
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'hAB00_0100, 32'd0, 32'h1234_5678, "LW_hi_addr");

    // Asynchronous reset while the address is being shifted.
    sel = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
    @(posedge clk);
    #1 drive_req(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    cnt = 0;
    while (m_bits < 12 && cnt < 200) begin @(negedge clk); cnt++; end
    chk("rst_mid reached ADDR", 32'(m_bits >= 12), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid cs_n", 32'(cs1), 32'd1);
    chk("rst_mid sclk", 32'(sclk1), 32'd0);
    chk("rst_mid busy", 32'(busy1), 32'd0);
    chk("rst_mid read_data", rdata1, 32'd0);
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (resp1) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (resp1) seen = 1'b1; end
    chk("rst_mid no_response", 32'(seen), 32'd0);
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'h1234_5678, "LW_after_rst");

    // Back-to-back: request held across the response is re-accepted.
    sel = 1'b0;
    sb_q.push_back(32'h1234_5678);
    sb_q.push_back(32'h1234_5678);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
    cnt = 0;
    while (!resp1 && cnt < 400) begin @(negedge clk); cnt++; end
    chk("b2b first resp", 32'(resp1), 32'd1);
    chk("b2b first data", rdata1, (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF);
    gap = 0;
    while (cs1 && gap < 20) begin gap++; @(negedge clk); end
    drive_req(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("b2b cs_high_cycles", 32'(gap), 32'd3);
    cnt = 0;
    while (!resp1 && cnt < 400) begin @(negedge clk); cnt++; end
    chk("b2b second resp", 32'(resp1), 32'd1);
    chk("b2b second data", rdata1, (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF);
    repeat (8) @(negedge clk);
    chk("b2b idle after", 32'(busy1), 32'd0);
    chk("b2b scoreboard empty", 32'(sb_q.size()), 32'd0);

    // CLK_DIV=3 instance: read+write together issues a write.
    access(1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 32'd0, "SW3_both");
    access(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'hCAFE_F00D, "LW3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
